rca_seq_adder: RTL
==================

Name: rca_seq_adder

Overview:
Multi-cycle sequencer that adds two WIDTH-bit operands with a single shared 4-bit ripple-carry stage, one nibble per clock, LSB first. Carry is registered between nibbles. Start/busy/done handshake on the control side. Intended as the area-lean wide adder built around the team's 4-bit RCA datapath.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 4
NIBBLES, WIDTH/4, derived local constant; number of add cycles per operation

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
a  input  WIDTH  operand A; sampled on the accepting edge
b  input  WIDTH  operand B; sampled on the accepting edge
cin  input  1  carry-in; sampled on the accepting edge
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when sum/cout become valid
sum  output  WIDTH  registered result; held until the next done
cout  output  1  registered final carry; held until the next done

Behaviour:
- Reset is asynchronous, active-low: state=IDLE, busy=0, done=0, sum=0, cout=0, nibble index=0, carry register=0, operand registers=0.
- States: IDLE, RUN.
- IDLE: on a clk edge with start=1, latch a, b, cin into internal registers, clear index to 0, go to RUN, busy=1. done is cleared on every edge unless set by RUN completion.
- RUN, per edge: stage inputs are operand nibble [4*idx+3 : 4*idx] of A and B plus the carry register. Write the stage sum into the working-sum nibble idx, write the stage carry-out into the carry register, then idx+1.
- On the edge that processes idx=NIBBLES-1: copy the completed working sum to sum and the final carry to cout, pulse done=1, set busy=0, and return to IDLE.
- Latency: with the accepting edge as edge 0, done and the result are visible after edge NIBBLES (4 for WIDTH=16). Throughput is one operation per NIBBLES+1 cycles.
- start while busy=1 is ignored. Operand changes during RUN have no effect.
- A start on the cycle done=1 is accepted, because busy=0 in that cycle. This gives back-to-back operation with no bubble beyond the accepting edge.
- sum and cout change only on the done edge. Intermediate nibbles are never visible on the outputs.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Overflow is carried only in cout. No signed interpretation.
- Reset mid-RUN: the operation is aborted immediately. No done is produced and the outputs return to their reset values.
- WIDTH=4: a single RUN cycle. This is a legal degenerate case.

Decomposition:
- Shared package: state encoding (IDLE, RUN), NIBBLE_W=4, and an index-width helper constant (clog2 of NIBBLES, minimum 1).
- One sub-module: rca4_stage. Purely combinational 4-bit ripple-carry adder with inputs a[3:0], b[3:0], cin and outputs sum[3:0], cout. It is instantiated exactly once and shared across all cycles.

Test Plan:
- Reset then idle: hold rst_n=0 -> busy=0, done=0, sum=0, cout=0. Release and hold start=0 for 10 cycles -> no change.
- Basic add, WIDTH=16: a=0x1234, b=0x4321, cin=0, start for 1 cycle -> busy high for 4 cycles; done pulses after edge 4; sum=0x5555, cout=0.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. Also a=0x000B, b=0x0003, cin=1 -> sum=0x000F, cout=0.
- Busy protection: start a=0x0100, b=0x0200; during RUN, pulse start with a=0xFFFF, b=0xFFFF and change the operand inputs -> exactly one done; sum=0x0300.
- Back-to-back: assert start with new operands (0x8000 + 0x8000, cin=1) in the cycle done=1 -> the second done comes 5 cycles after the first, with sum=0x0001, cout=1. The first result is held until then.
- Reset mid-operation: drop rst_n two cycles into RUN -> outputs go to 0 asynchronously. After release there is no done. A subsequent start completes normally.

Source files
------------

// File: rtl/rca_seq_adder_pkg.sv
// Shared definitions for the nibble-serial adder.
// State encoding, stage width and index sizing.
package rca_seq_adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rca4_stage.sv
// Combinational 4-bit ripple-carry adder.
// Shared by every nibble cycle of the sequencer.
module rca4_stage (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [4:0] c;

   always_comb begin
      c[0] = cin;
      for (int i = 0; i < 4; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      cout = c[4];
   end

endmodule

// File: rtl/rca_seq_adder.sv
// Wide adder built from one shared 4-bit RCA stage.
// Processes one nibble per clock, LSB first.
module rca_seq_adder
   import rca_seq_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int IDX_W   = idx_w(NIBBLES);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

   state_t state, state_nx;

   logic [WIDTH-1:0] op_a, op_b;
   logic [WIDTH-1:0] work, work_nx;
   logic [IDX_W-1:0] idx;
   logic [IDX_W+1:0] base;
   logic             carry;
   logic             accept, last;

   logic [3:0] st_a, st_b, st_s;
   logic       st_co;

   rca4_stage u_stage (
      .a    (st_a),
      .b    (st_b),
      .cin  (carry),
      .sum  (st_s),
      .cout (st_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      accept   = 1'b0;
      last     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (idx == LAST) begin
               last     = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Nibble select and working-sum merge for the current index.
   always_comb begin
      base    = {idx, 2'b00};
      st_a    = op_a[base +: NIBBLE_W];
      st_b    = op_b[base +: NIBBLE_W];
      work_nx = work;
      work_nx[base +: NIBBLE_W] = st_s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a  <= '0;
         op_b  <= '0;
         work  <= '0;
         idx   <= '0;
         carry <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            idx   <= '0;
            work  <= '0;
         end else if (busy) begin
            work  <= work_nx;
            carry <= st_co;
            idx   <= idx + 1'b1;
            // Results only move on completion.
            if (last) begin
               sum  <= work_nx;
               cout <= st_co;
               done <= 1'b1;
            end
         end
      end
   end

endmodule
